regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Shares the single register-file write port (we3/a3/wd3) among NREQ writeback requesters, such as ALU result, load data and CSR read, using a valid/ready handshake. It sits between the pipeline writeback sources and `regfile`. It grants at most one requester per cycle, registers the winning write onto the port, drops architectural writes to x0, and publishes a per-register in-flight mask for hazard logic.

## Interface
- NREQ, 3, number of writeback requesters (2..8)
- XLEN, 32, data width
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  requester i has a write pending
- req_addr  input  NREQ x 5  destination register per requester
- req_data  input  NREQ x XLEN  write data per requester
- req_ready  output  NREQ  one-hot grant; transfer when valid & ready
- wb_hold  input  1  when high, no grants issued
- we3  output  1  regfile write enable (registered)
- a3  output  5  regfile write address (registered)
- wd3  output  XLEN  regfile write data (registered)
- grant_id  output  $clog2(NREQ)  index of the requester whose write is on the port
- busy_mask  output  32  bit r set while a write to r is on the port

## Operation
- Combinational grant: req_ready[i] = 1 for exactly the winning requester when wb_hold=0 and any req_valid is set; otherwise all zero. It is never asserted for a non-valid requester.
- Winner selection: round-robin starting from rr_ptr (see Configuration).
- The output stage loads every cycle:
  - On a grant: we3 = (req_addr[w] != 0), a3 = req_addr[w], wd3 = req_data[w], grant_id = w.
  - With no grant: we3 = 0, and a3/wd3/grant_id hold their values.
- An x0 write is accepted (ready asserted, requester released) but suppressed: we3 = 0.
- busy_mask = one-hot(a3) when we3 = 1, else 0. Bit 0 is always 0.
- rr_ptr update on a grant to w: rr_ptr = (w+1) mod NREQ, wrapping from NREQ-1 to 0. It is unchanged when there is no grant or wb_hold=1.
- A requester must hold valid/addr/data stable until it sees ready. The arbiter does not depend on this, but the bench checks it.
- wb_hold has priority over all requests. Asserting it mid-stream drains the output stage in one cycle.

## Timing
- Reset, asynchronous and immediate: we3=0, a3=0, wd3=0, grant_id=0, busy_mask=0, rr_ptr=0. req_ready is combinational and therefore 0 while rst_n is low.
- Accept at rising edge N, then we3/a3/wd3 are valid from N until N+1. `regfile` commits at the falling edge inside that cycle, so the data is readable from the second half of cycle N.
- Throughput is one write per cycle. Back-to-back grants to the same requester are allowed under fixed priority.
- Simultaneous valids from all requesters are served in NREQ consecutive cycles under round-robin, with no requester starving.
- When reset is asserted mid-write, we3 drops asynchronously and the write in flight is lost. Requesters must re-present after reset.

## Configuration
- RF_WB_RR_EN defined: round-robin arbitration with rr_ptr as described.
- RF_WB_RR_EN undefined: fixed priority, lowest index wins. rr_ptr is removed and grant_id still reports the winner.

## Structure
- The shared package (riscv_pkg) holds:
  - REG_ADDR_W=5 and NUM_REGS=32.
  - A typedef for a writeback request struct {valid, addr, data}.
- One sub-module is natural: rr_arbiter (NREQ-wide request vector, pointer, one-hot grant output). In fixed-priority builds it degenerates to a priority encoder.

## Test plan
- Reset with all req_valid=1, then release rst_n: during reset req_ready=0 and we3=0. In the first cycle after release, requester 0 is granted.
- Single request: req_valid=001, addr=5, data=0xDEADBEEF. After the edge: we3=1, a3=5, wd3=0xDEADBEEF, busy_mask=0x20, grant_id=0. A regfile read of x5 returns 0xDEADBEEF.
- All three requesters valid continuously (RR build): grants cycle 0,1,2,0. Fixed-priority build: requester 0 is granted every cycle.
- x0 write: req_addr=0, data=0x1234 is accepted (ready=1) but we3=0 and busy_mask=0. Reading x0 still returns 0.
- Hold: wb_hold=1 with requests valid gives ready=000 and we3=0 on the next edge, with rr_ptr unchanged. Releasing hold resumes from the same pointer.
- Asserting rst_n=0 mid-stream while we3=1: we3 goes to 0 immediately without a clock edge, and rr_ptr returns to 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// ============================================================================
// Module      : regfile_wb_arbiter_pkg
// Description : Shared types and constants for the register-file writeback
//               arbiter: register-file geometry, the writeback request record
//               and a helper that expands a register address into a bit mask.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int WB_DATA_W  = 32;

    // One writeback request as presented by a pipeline source.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0]  data;
    } wb_req_t;

    // One-hot register mask; x0 never appears because it is never written.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] m;
        m       = '0;
        m[addr] = 1'b1;
        m[0]    = 1'b0;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// ============================================================================
// Module      : regfile_wb_arbiter_rr_arbiter
// Description : Combinational round-robin arbiter. Searches the request vector
//               starting at ptr and grants the first set bit. With ptr tied to
//               zero it is a lowest-index-wins priority encoder.
// Ports       : req      - request vector (NREQ)
//               ptr      - search start index (0..NREQ-1)
//               gnt      - one-hot grant
//               gnt_idx  - index of the granted requester
//               gnt_any  - any grant issued
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter_rr_arbiter #(
    parameter  int NREQ  = 3,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    always_comb begin
        int               w_sum;
        logic [IDX_W-1:0] w_idx;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        w_sum   = 0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            // Wrap ptr+k back into 0..NREQ-1 (NREQ need not be a power of two).
            w_sum = int'(ptr) + k;
            if (w_sum >= NREQ) begin
                w_sum = w_sum - NREQ;
            end
            w_idx = IDX_W'(w_sum);
            if (!gnt_any && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                gnt_idx    = w_idx;
                gnt_any    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the single register-file write port (we3/a3/wd3) among
//               NREQ writeback requesters with a valid/ready handshake. At most
//               one grant per cycle; the winning write is registered onto the
//               port. Writes to x0 are accepted but suppressed. busy_mask flags
//               the register whose write is currently on the port.
// Config      : RF_WB_RR_EN defined   -> round-robin arbitration (rr_ptr)
//               RF_WB_RR_EN undefined -> fixed priority, lowest index wins
// Ports       : clk, rst_n (async, active low)
//               req_valid/req_addr/req_data  - requester inputs (NREQ wide)
//               req_ready                    - one-hot grant
//               wb_hold                      - suppress all grants
//               we3/a3/wd3                   - registered regfile write port
//               grant_id                     - winner behind the port contents
//               busy_mask                    - in-flight register mask
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NREQ-1:0]                     req_valid,
    input  logic [NREQ-1:0][REG_ADDR_W-1:0]     req_addr,
    input  logic [NREQ-1:0][XLEN-1:0]           req_data,
    output logic [NREQ-1:0]                     req_ready,
    input  logic                                wb_hold,
    output logic                                we3,
    output logic [REG_ADDR_W-1:0]               a3,
    output logic [XLEN-1:0]                     wd3,
    output logic [$clog2(NREQ)-1:0]             grant_id,
    output logic [NUM_REGS-1:0]                 busy_mask
);

    localparam int c_IDX_W = $clog2(NREQ);

    logic [NREQ-1:0]       w_req;
    logic [NREQ-1:0]       w_gnt;
    logic [c_IDX_W-1:0]    w_gnt_idx;
    logic                  w_gnt_any;
    logic [c_IDX_W-1:0]    w_ptr;

    logic                  r_we3;
    logic [REG_ADDR_W-1:0] r_a3;
    logic [XLEN-1:0]       r_wd3;
    logic [c_IDX_W-1:0]    r_grant_id;

    // Hold and reset both mask the request vector so that ready can never
    // rise while either is active.
    assign w_req = req_valid & {NREQ{~wb_hold & rst_n}};

    regfile_wb_arbiter_rr_arbiter #(
        .NREQ    (NREQ)
    ) u_arb (
        .req     (w_req),
        .ptr     (w_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .gnt_any (w_gnt_any)
    );

`ifdef RF_WB_RR_EN
    logic [c_IDX_W-1:0] r_rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_gnt_any) begin
            r_rr_ptr <= (w_gnt_idx == c_IDX_W'(NREQ - 1)) ? '0 : w_gnt_idx + c_IDX_W'(1);
        end
    end

    assign w_ptr = r_rr_ptr;
`else
    assign w_ptr = '0;
`endif

    // Output stage: reload on every grant; otherwise only we3 drops and the
    // address/data/id hold their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we3      <= 1'b0;
            r_a3       <= '0;
            r_wd3      <= '0;
            r_grant_id <= '0;
        end else if (w_gnt_any) begin
            r_we3      <= (req_addr[w_gnt_idx] != '0);
            r_a3       <= req_addr[w_gnt_idx];
            r_wd3      <= req_data[w_gnt_idx];
            r_grant_id <= w_gnt_idx;
        end else begin
            r_we3      <= 1'b0;
        end
    end

    assign req_ready = w_gnt;
    assign we3       = r_we3;
    assign a3        = r_a3;
    assign wd3       = r_wd3;
    assign grant_id  = r_grant_id;
    assign busy_mask = r_we3 ? reg_onehot(r_a3) : '0;

endmodule

`default_nettype wire
